less_distance_sel: RTL and testbench

- Given an unsigned reference value and two unsigned candidates, the block picks the candidate closer to the reference. Distance is the absolute difference.
- The chosen candidate is registered. A select flag and a valid flag are registered with it.
- Used as a nearest-value picker in datapath stages such as quantizers and tracking loops. It operates on one sample per clock.

---
 rtl/less_distance_pkg.sv | 11 +
 rtl/less_distance_sel_abs_diff.sv | 14 +
 rtl/less_distance_sel.sv | 85 ++++++++
 tb/tb_less_distance_sel.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/less_distance_pkg.sv
// Shared width default and select encoding for the less_distance_sel nearest-value picker.
package less_distance_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/less_distance_sel_abs_diff.sv
// Purely combinational unsigned magnitude |x - y|; never wraps, so the result always fits WIDTH bits.
module abs_diff
  import less_distance_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff
);

  assign diff = (x >= y) ? (x - y) : (y - x);

endmodule

// File: rtl/less_distance_sel.sv
// Registers whichever of a_i/b_i is closer to ref_i (ties pick A), one cycle after in_valid.
// Define LESS_DISTANCE_DIST_OUT_EN to add the registered winning distance on dist_o.
module less_distance_sel
  import less_distance_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ref_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_o,
  output logic             sel_o
`ifdef LESS_DISTANCE_DIST_OUT_EN
  ,
  output logic [WIDTH-1:0] dist_o
`endif
);

  logic [WIDTH-1:0] dist_a;
  logic [WIDTH-1:0] dist_b;
  sel_e             sel_next;
  logic [WIDTH-1:0] out_next;
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  sel_e             sel_q;

  abs_diff #(.WIDTH(WIDTH)) u_diff_a (
    .x    (ref_i),
    .y    (a_i),
    .diff (dist_a)
  );

  abs_diff #(.WIDTH(WIDTH)) u_diff_b (
    .x    (ref_i),
    .y    (b_i),
    .diff (dist_b)
  );

  // Strict less-than so an equal distance keeps candidate A.
  always_comb begin
    sel_next = SEL_A;
    out_next = a_i;
    if (dist_b < dist_a) begin
      sel_next = SEL_B;
      out_next = b_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      sel_q   <= SEL_A;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        out_q <= out_next;
        sel_q <= sel_next;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_o     = out_q;
  assign sel_o     = sel_q;

`ifdef LESS_DISTANCE_DIST_OUT_EN
  logic [WIDTH-1:0] dist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q <= '0;
    end else if (in_valid) begin
      dist_q <= (sel_next == SEL_B) ? dist_b : dist_a;
    end
  end

  assign dist_o = dist_q;
`endif

endmodule

// File: tb/tb_less_distance_sel.sv
// Self-checking bench for less_distance_sel: integer reference model checked every negedge plus literal vectors.
module tb_less_distance_sel;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] ref_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             out_valid;
  logic [WIDTH-1:0] out_o;
  logic             sel_o;
`ifdef LESS_DISTANCE_DIST_OUT_EN
  logic [WIDTH-1:0] dist_o;
`endif

  int checks;
  int errors;
  bit check_en;

  // Model state: what the outputs must show after the most recent edge.
  int m_valid;
  int m_out;
  int m_sel;
  int m_dist;

  less_distance_sel #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ref_i     (ref_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_o     (out_o),
    .sel_o     (sel_o)
`ifdef LESS_DISTANCE_DIST_OUT_EN
    ,
    .dist_o    (dist_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int absDist(int r, int c);
    return (r > c) ? (r - c) : (c - r);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0;
      m_out   <= 0;
      m_sel   <= 0;
      m_dist  <= 0;
    end else begin
      m_valid <= int'(in_valid);
      if (in_valid) begin
        if (absDist(int'(ref_i), int'(b_i)) < absDist(int'(ref_i), int'(a_i))) begin
          m_out  <= int'(b_i);
          m_sel  <= 1;
          m_dist <= absDist(int'(ref_i), int'(b_i));
        end else begin
          m_out  <= int'(a_i);
          m_sel  <= 0;
          m_dist <= absDist(int'(ref_i), int'(a_i));
        end
      end
    end
  end

  task automatic compareOne(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model checker, active on every cycle once enabled.
  always @(negedge clk) begin
    if (check_en) begin
      compareOne("model_valid", int'(out_valid), m_valid);
      compareOne("model_out", int'(out_o), m_out);
      compareOne("model_sel", int'(sel_o), m_sel);
`ifdef LESS_DISTANCE_DIST_OUT_EN
      compareOne("model_dist", int'(dist_o), m_dist);
`endif
    end
  end

  task automatic applyStimulus(logic v, logic [WIDTH-1:0] r, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    @(negedge clk);
    in_valid = v;
    ref_i    = r;
    a_i      = a;
    b_i      = b;
  endtask

  task automatic checkOutput(string name, bit wait_edge, int v, int o, int s, int d);
    if (wait_edge) @(negedge clk);
    compareOne({name, "_valid"}, int'(out_valid), v);
    compareOne({name, "_out"}, int'(out_o), o);
    compareOne({name, "_sel"}, int'(sel_o), s);
`ifdef LESS_DISTANCE_DIST_OUT_EN
    compareOne({name, "_dist"}, int'(dist_o), d);
`else
    if (d < 0) $display("[TB] unexpected negative distance %0d", d);
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ref_i    = '0;
    a_i      = '0;
    b_i      = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    check_en = 1'b1;

    applyStimulus(1'b1, 8'h6F, 8'h56, 8'h35);
    checkOutput("basic", 1'b1, 1, 'h56, 0, 'h19);

    applyStimulus(1'b1, 8'd100, 8'd90, 8'd110);
    checkOutput("tie", 1'b1, 1, 90, 0, 10);

    applyStimulus(1'b1, 8'h00, 8'hFF, 8'h80);
    checkOutput("nowrap_lo", 1'b1, 1, 'h80, 1, 'h80);

    applyStimulus(1'b1, 8'hFF, 8'h00, 8'hFE);
    checkOutput("nowrap_hi", 1'b1, 1, 'hFE, 1, 1);

    applyStimulus(1'b1, 8'h42, 8'h10, 8'h42);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("hold", 1'b1, 0, 'h42, 1, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)));
      if (i == 5) begin
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 0, 0, 0, 0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_again", 1'b0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    checkOutput("idle_after_reset", 1'b1, 0, 0, 0, 0);
    applyStimulus(1'b1, 8'h20, 8'h30, 8'h18);
    checkOutput("resume", 1'b1, 1, 'h18, 1, 8);

    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
